// File: rtl/rcpu_mem_arbiter_if.sv
// Bus bundle between the RCPU core, the boot loader and the single-port program/data RAM.
// The arbiter uses the slave view; the surrounding system (core, loader, RAM) uses the master view.
interface rcpu_mem_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              cpu_resetq;
    logic              cpu_hold;
    logic              cpu_re;
    logic [ADDR_W-1:0] cpu_raddr;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_waddr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_gnt;
    logic              ldr_rvalid;
    logic [DATA_W-1:0] ldr_rdata;
    logic              ldr_done;
    logic              ldr_halt;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        output cpu_resetq, cpu_hold, cpu_rdata,
        input  cpu_re, cpu_raddr, cpu_we, cpu_waddr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_done, ldr_halt,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        input  cpu_resetq, cpu_hold, cpu_rdata,
        output cpu_re, cpu_raddr, cpu_we, cpu_waddr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_done, ldr_halt,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/rcpu_mem_arbiter.sv
// Shares the program/data RAM between the RCPU core and the boot loader, and owns the core reset.
// LOAD keeps the core in reset; RUN gives the core priority; STEAL forces one loader cycle.
module rcpu_mem_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16
) (
    input  logic                 clk,
    input  logic                 resetq,
    rcpu_mem_arbiter_if.slave    bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_STEAL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              gnt;
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

    logic              vld_p1;
    logic              ldr_own_p1;
    logic [DATA_W-1:0] cpu_rdata_p1;
    logic              cpu_rvld;

    // Next state, RAM port drive and starvation count; everything idles while resetq is low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        en      = 1'b0;
        we      = 1'b0;
        addr    = '0;
        wdata   = '0;
        if (resetq) begin
            case (state_q)
                S_LOAD: begin
                    cnt_d = '0;
                    if (bus.ldr_req) begin
                        gnt   = 1'b1;
                        en    = 1'b1;
                        we    = bus.ldr_we;
                        addr  = bus.ldr_addr;
                        wdata = bus.ldr_wdata;
                    end
                    if (bus.ldr_done) state_d = S_RUN;
                end
                S_RUN: begin
                    if (bus.cpu_we) begin
                        en    = 1'b1;
                        we    = 1'b1;
                        addr  = bus.cpu_waddr;
                        wdata = bus.cpu_wdata;
                    end else if (bus.cpu_re) begin
                        en    = 1'b1;
                        addr  = bus.cpu_raddr;
                    end else if (bus.ldr_req) begin
                        gnt   = 1'b1;
                        en    = 1'b1;
                        we    = bus.ldr_we;
                        addr  = bus.ldr_addr;
                        wdata = bus.ldr_wdata;
                    end
                    if (gnt) cnt_d = '0;
                    else if (bus.ldr_req && (cnt_q != LIMIT)) cnt_d = cnt_q + CNT_W'(1);
                    if (bus.ldr_halt) begin
                        state_d = S_LOAD;
                        cnt_d   = '0;
                    end else if (cnt_d == LIMIT) begin
                        state_d = S_STEAL;
                    end
                end
                S_STEAL: begin
                    cnt_d = '0;
                    if (bus.ldr_req) begin
                        gnt   = 1'b1;
                        en    = 1'b1;
                        we    = bus.ldr_we;
                        addr  = bus.ldr_addr;
                        wdata = bus.ldr_wdata;
                    end
                    state_d = bus.ldr_halt ? S_LOAD : S_RUN;
                end
                default: state_d = S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stage p1: RAM read data returns; steer it by who owned the read.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            vld_p1       <= 1'b0;
            ldr_own_p1   <= 1'b0;
            cpu_rdata_p1 <= '0;
        end else begin
            vld_p1       <= en & ~we;
            ldr_own_p1   <= gnt;
            cpu_rdata_p1 <= bus.cpu_rdata;
        end
    end

    assign cpu_rvld       = vld_p1 & ~ldr_own_p1;

    assign bus.cpu_rdata  = cpu_rvld ? bus.ram_rdata : cpu_rdata_p1;
    assign bus.ldr_rvalid = vld_p1 & ldr_own_p1;
    assign bus.ldr_rdata  = bus.ldr_rvalid ? bus.ram_rdata : '0;

    assign bus.cpu_resetq = (state_q != S_LOAD);
    assign bus.cpu_hold   = (state_q == S_STEAL);
    assign bus.ldr_gnt    = gnt;
    assign bus.ram_en     = en;
    assign bus.ram_we     = we;
    assign bus.ram_addr   = addr;
    assign bus.ram_wdata  = wdata;

endmodule

// File: tb/tb_rcpu_mem_arbiter.sv
// Directed bench for rcpu_mem_arbiter: a behavioural 1-cycle-latency RAM sits behind the arbiter,
// the core and loader are driven from one linear stimulus sequence.
module tb_rcpu_mem_arbiter;

    logic clk;
    logic resetq;

    int checks   = 0;
    int failures = 0;

    rcpu_mem_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    rcpu_mem_arbiter #(.STARVE_LIMIT(8), .DATA_W(16), .ADDR_W(16)) dut (
        .clk    (clk),
        .resetq (resetq),
        .bus    (bus)
    );

    logic [15:0] mem [0:255];

    always_ff @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
            else            bus.ram_rdata <= mem[bus.ram_addr[7:0]];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cpu_re    = 1'b0;
        bus.cpu_raddr = 16'h0000;
        bus.cpu_we    = 1'b0;
        bus.cpu_waddr = 16'h0000;
        bus.cpu_wdata = 16'h0000;
        bus.ldr_req   = 1'b0;
        bus.ldr_we    = 1'b0;
        bus.ldr_addr  = 16'h0000;
        bus.ldr_wdata = 16'h0000;
        bus.ldr_done  = 1'b0;
        bus.ldr_halt  = 1'b0;
    endtask

    logic [15:0] img [0:3];

    initial begin
        img[0] = 16'h1234;
        img[1] = 16'h5678;
        img[2] = 16'h9ABC;
        img[3] = 16'hDEF0;
        resetq = 1'b0;
        idle_inputs();

        // Reset values
        cyc();
        cyc();
        chk("rst_cpu_resetq", 32'(bus.cpu_resetq), 32'h0);
        chk("rst_cpu_hold",   32'(bus.cpu_hold),   32'h0);
        chk("rst_ldr_gnt",    32'(bus.ldr_gnt),    32'h0);
        chk("rst_ldr_rvalid", 32'(bus.ldr_rvalid), 32'h0);
        chk("rst_cpu_rdata",  32'(bus.cpu_rdata),  32'h0);
        chk("rst_ram_en",     32'(bus.ram_en),     32'h0);
        chk("rst_ram_we",     32'(bus.ram_we),     32'h0);
        chk("rst_ram_addr",   32'(bus.ram_addr),   32'h0);
        chk("rst_ram_wdata",  32'(bus.ram_wdata),  32'h0);
        resetq = 1'b1;
        cyc();

        // LOAD: image writes, core requests must be ignored
        for (int i = 0; i < 4; i++) begin
            bus.ldr_req   = 1'b1;
            bus.ldr_we    = 1'b1;
            bus.ldr_addr  = 16'(i);
            bus.ldr_wdata = img[i];
            bus.cpu_re    = 1'b1;
            bus.cpu_raddr = 16'h00FF;
            #1;
            chk("load_wr_gnt",   32'(bus.ldr_gnt),    32'h1);
            chk("load_wr_we",    32'(bus.ram_we),     32'h1);
            chk("load_wr_addr",  32'(bus.ram_addr),   32'(i));
            chk("load_wr_data",  32'(bus.ram_wdata),  32'(img[i]));
            chk("load_cpu_rstq", 32'(bus.cpu_resetq), 32'h0);
            cyc();
        end
        idle_inputs();
        bus.ldr_req  = 1'b1;
        bus.ldr_addr = 16'h0002;
        #1;
        chk("load_rd_gnt", 32'(bus.ldr_gnt), 32'h1);
        chk("load_rd_we",  32'(bus.ram_we),  32'h0);
        cyc();
        idle_inputs();
        #1;
        chk("load_rd_rvalid", 32'(bus.ldr_rvalid), 32'h1);
        chk("load_rd_rdata",  32'(bus.ldr_rdata),  32'h9ABC);
        chk("load_rd_gnt_off", 32'(bus.ldr_gnt),   32'h0);
        chk("load_cpu_rstq2", 32'(bus.cpu_resetq), 32'h0);
        cyc();

        // ldr_done -> RUN, core released next cycle
        bus.ldr_done = 1'b1;
        #1;
        chk("done_cpu_rstq_same", 32'(bus.cpu_resetq), 32'h0);
        cyc();
        idle_inputs();
        #1;
        chk("run_cpu_rstq", 32'(bus.cpu_resetq), 32'h1);

        // RUN: core read of 0x0001
        bus.cpu_re    = 1'b1;
        bus.cpu_raddr = 16'h0001;
        #1;
        chk("run_cpu_rd_en",   32'(bus.ram_en),   32'h1);
        chk("run_cpu_rd_addr", 32'(bus.ram_addr), 32'h0001);
        cyc();
        idle_inputs();
        #1;
        chk("run_cpu_rdata",  32'(bus.cpu_rdata),  32'h5678);
        chk("run_cpu_no_rv",  32'(bus.ldr_rvalid), 32'h0);

        // Loader read on a core-idle cycle
        bus.ldr_req  = 1'b1;
        bus.ldr_addr = 16'h0000;
        #1;
        chk("run_ldr_gnt", 32'(bus.ldr_gnt), 32'h1);
        cyc();
        idle_inputs();
        #1;
        chk("run_ldr_rvalid", 32'(bus.ldr_rvalid), 32'h1);
        chk("run_ldr_rdata",  32'(bus.ldr_rdata),  32'h1234);
        chk("run_cpu_hold_rd", 32'(bus.cpu_rdata), 32'h5678);
        cyc();

        // Starvation: core reads every cycle, loader waits 8 cycles then STEAL
        for (int i = 0; i < 8; i++) begin
            bus.cpu_re    = 1'b1;
            bus.cpu_raddr = 16'h0001;
            bus.ldr_req   = 1'b1;
            bus.ldr_addr  = 16'h0003;
            #1;
            chk("starve_no_gnt",  32'(bus.ldr_gnt),  32'h0);
            chk("starve_no_hold", 32'(bus.cpu_hold), 32'h0);
            cyc();
        end
        #1;
        chk("steal_hold",     32'(bus.cpu_hold),  32'h1);
        chk("steal_gnt",      32'(bus.ldr_gnt),   32'h1);
        chk("steal_addr",     32'(bus.ram_addr),  32'h0003);
        chk("steal_cpu_rd",   32'(bus.cpu_rdata), 32'h5678);
        cyc();
        idle_inputs();
        #1;
        chk("steal_rvalid",   32'(bus.ldr_rvalid), 32'h1);
        chk("steal_rdata",    32'(bus.ldr_rdata),  32'hDEF0);
        chk("steal_hold_off", 32'(bus.cpu_hold),   32'h0);
        chk("steal_cpu_keep", 32'(bus.cpu_rdata),  32'h5678);
        cyc();

        // Write wins over read in the same cycle
        bus.cpu_we    = 1'b1;
        bus.cpu_waddr = 16'h0010;
        bus.cpu_wdata = 16'hAAAA;
        bus.cpu_re    = 1'b1;
        bus.cpu_raddr = 16'h0001;
        #1;
        chk("wr_win_we",   32'(bus.ram_we),    32'h1);
        chk("wr_win_addr", 32'(bus.ram_addr),  32'h0010);
        chk("wr_win_data", 32'(bus.ram_wdata), 32'hAAAA);
        cyc();
        idle_inputs();
        #1;
        chk("wr_no_rvalid",   32'(bus.ldr_rvalid), 32'h0);
        chk("wr_cpu_rd_keep", 32'(bus.cpu_rdata),  32'h5678);
        bus.ldr_req  = 1'b1;
        bus.ldr_addr = 16'h0010;
        #1;
        chk("wr_rb_gnt", 32'(bus.ldr_gnt), 32'h1);
        cyc();
        idle_inputs();
        #1;
        chk("wr_rb_rvalid", 32'(bus.ldr_rvalid), 32'h1);
        chk("wr_rb_rdata",  32'(bus.ldr_rdata),  32'hAAAA);
        cyc();

        // Halt and done together: halt wins
        bus.ldr_halt = 1'b1;
        bus.ldr_done = 1'b1;
        #1;
        chk("halt_rstq_same", 32'(bus.cpu_resetq), 32'h1);
        cyc();
        idle_inputs();
        #1;
        chk("halt_rstq", 32'(bus.cpu_resetq), 32'h0);

        // Reset asserted during a granted loader read
        bus.cpu_re    = 1'b1;
        bus.cpu_raddr = 16'h0001;
        bus.ldr_req   = 1'b1;
        bus.ldr_addr  = 16'h0002;
        #1;
        chk("halt_load_gnt",  32'(bus.ldr_gnt),  32'h1);
        chk("halt_load_addr", 32'(bus.ram_addr), 32'h0002);
        resetq = 1'b0;
        #1;
        chk("rst_async_gnt", 32'(bus.ldr_gnt), 32'h0);
        chk("rst_async_en",  32'(bus.ram_en),  32'h0);
        cyc();
        idle_inputs();
        #1;
        chk("rst2_rvalid",    32'(bus.ldr_rvalid), 32'h0);
        chk("rst2_cpu_rdata", 32'(bus.cpu_rdata),  32'h0);
        resetq = 1'b1;
        cyc();
        chk("rel_rvalid",  32'(bus.ldr_rvalid), 32'h0);
        chk("rel_gnt",     32'(bus.ldr_gnt),    32'h0);
        chk("rel_rstq",    32'(bus.cpu_resetq), 32'h0);
        chk("rel_hold",    32'(bus.cpu_hold),   32'h0);
        chk("rel_cpu_rd",  32'(bus.cpu_rdata),  32'h0);
        chk("rel_ram_en",  32'(bus.ram_en),     32'h0);
        chk("rel_ram_we",  32'(bus.ram_we),     32'h0);
        chk("rel_ram_adr", 32'(bus.ram_addr),   32'h0);
        chk("rel_ram_wd",  32'(bus.ram_wdata),  32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
